// File: rtl/alu_32_core_if.sv
// Operand/result bundle for the 32-bit execute-stage ALU.
// The master drives the operands; the slave returns the registered result and flags.
interface alu_32_core_if;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic [31:0] out_resultado;
  logic        zero;
  logic        carry_out;
  logic        overflow;

  modport master (
    output in_valid, a, b, alu_control,
    input  out_valid, out_resultado, zero, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, alu_control,
    output out_valid, out_resultado, zero, carry_out, overflow
  );
endinterface

// File: rtl/alu_32_core.sv
// 32-bit ALU with MIPS-style op encoding.
// Result and flags are registered, giving one cycle of latency; they hold while in_valid is low.
module alu_32_core #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_32_core_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  logic             r_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;

  // The top bit of the 33-bit subtraction is the no-borrow carry.
  assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};

  assign w_add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                     (w_add[WIDTH-1] != bus.a[WIDTH-1]);
  assign w_sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                     (w_sub[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.alu_control)
      OP_AND: w_res = bus.a & bus.b;
      OP_OR:  w_res = bus.a | bus.b;
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = w_add_ovf;
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = w_sub_ovf;
      end
      // XOR with overflow keeps the sign test correct across the full signed range.
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
      OP_NOR: w_res = ~(bus.a | bus.b);
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_res   <= w_res;
        r_zero  <= (w_res == '0);
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
      end
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.out_resultado = r_res;
  assign bus.zero          = r_zero;
  assign bus.carry_out     = r_carry;
  assign bus.overflow      = r_ovf;

endmodule

// File: tb/tb_alu_32_core.sv
// Self-checking bench for alu_32_core: directed vectors pin the reference model,
// then random traffic is compared against it on every falling edge.
module tb_alu_32_core;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_32_core_if bus();

  alu_32_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  logic exp_valid;
  exp_t exp_out;

  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    exp_t             e;
    longint unsigned  ua;
    longint unsigned  ub;
    longint unsigned  us;
    longint           sa;
    longint           sb;
    longint           ss;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    e.res = 32'h0;
    e.c   = 1'b0;
    e.v   = 1'b0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        us    = ua + ub;
        e.res = us[31:0];
        e.c   = (us >= 64'h1_0000_0000);
        ss    = sa + sb;
        e.v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'b0110: begin
        e.res = a - b;
        e.c   = (ua >= ub);
        ss    = sa - sb;
        e.v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(a | b);
      default: e.res = 32'h0;
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic set_reset_exp();
    exp_valid   = 1'b0;
    exp_out.res = 32'h0;
    exp_out.z   = 1'b1;
    exp_out.c   = 1'b0;
    exp_out.v   = 1'b0;
  endtask

  // Called just after a falling edge: apply inputs, advance the model on the
  // rising edge, and return on the next falling edge.
  task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    bus.in_valid    = v;
    bus.a           = a;
    bus.b           = b;
    bus.alu_control = op;
    @(posedge clk);
    if (rst) begin
      set_reset_exp();
    end else begin
      exp_valid = v;
      if (v) exp_out = model(a, b, op);
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    chk("out_valid", {31'h0, bus.out_valid}, {31'h0, exp_valid});
    chk("result",    bus.out_resultado,      exp_out.res);
    chk("zero",      {31'h0, bus.zero},      {31'h0, exp_out.z});
    chk("carry",     {31'h0, bus.carry_out}, {31'h0, exp_out.c});
    chk("overflow",  {31'h0, bus.overflow},  {31'h0, exp_out.v});
  end

  vec_t vecs[15];
  logic [3:0] ops[6];
  logic [31:0] edges[6];

  initial begin
    exp_t m;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.in_valid    = 1'b0;
    bus.a           = 32'h0;
    bus.b           = 32'h0;
    bus.alu_control = 4'h0;
    set_reset_exp();

    vecs[0]  = '{32'hFFFF0000, 32'h0F0F0F0F, 4'b0000, 32'h0F0F0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF0000, 32'h0F0F0F0F, 4'b0001, 32'hFFFF0F0F, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'd200,      32'd150,      4'b0110, 32'd50,       1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'd50,       32'd100,      4'b0110, 32'hFFFFFFCE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'd7,        32'd7,        4'b0110, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[5]  = '{32'd100,      32'd50,       4'b0010, 32'd150,      1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h7FFFFFFF, 32'h1,        4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'hFFFFFFFF, 32'h1,        4'b0010, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[8]  = '{32'd30,       32'd50,       4'b0111, 32'd1,        1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'd50,       32'd30,       4'b0111, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'h80000000, 32'h7FFFFFFF, 4'b0111, 32'd1,        1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h80000000, 32'h1,        4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{32'hAAAA5555, 32'h5555AAAA, 4'b1100, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[13] = '{32'h12345678, 32'h9ABCDEF0, 4'b1111, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[14] = '{32'h7FFFFFFF, 32'h80000000, 4'b0111, 32'd0,        1'b1, 1'b0, 1'b0};

    ops   = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    edges = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000001};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].op);
      chk("model_res", m.res, vecs[i].res);
      chk("model_flags", {29'h0, m.z, m.c, m.v}, {29'h0, vecs[i].z, vecs[i].c, vecs[i].v});
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      chk("dir_res", bus.out_resultado, vecs[i].res);
      chk("dir_flags", {29'h0, bus.zero, bus.carry_out, bus.overflow},
          {29'h0, vecs[i].z, vecs[i].c, vecs[i].v});
    end

    // Idle cycles with garbage operands must leave the last result in place.
    drive(1'b0, 32'hDEADBEEF, 32'h1, 4'b0010);
    drive(1'b0, 32'h1, 32'h1, 4'b0110);

    for (int n = 0; n < 400; n++) begin
      ra  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 4) == 0) rb = ra;
      rop = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)];
      drive($urandom_range(0, 4) != 0, ra, rb, rop);
    end

    // Reset asserted between edges must clear outputs without a clock.
    drive(1'b1, 32'h7FFFFFFF, 32'h1, 4'b0010);
    bus.in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("async_rst_res",   bus.out_resultado, 32'h0);
    chk("async_rst_flags", {29'h0, bus.zero, bus.carry_out, bus.overflow}, 32'h4);
    set_reset_exp();
    @(negedge clk);
    drive(1'b1, 32'h5, 32'h3, 4'b0010);
    rst = 1'b0;
    drive(1'b1, 32'h5, 32'h3, 4'b0110);
    drive(1'b0, 32'h0, 32'h0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
